posit_packer: RTL and testbench

Two-stage pipelined posit encoder: packs an unpacked posit (sign, regime k, exponent, hidden-bit fraction, sticky) into a WIDTH-bit posit word of format `pFormat`. It applies round-to-nearest-even, never rounds to zero or NaR, and negates by two's complement. It sits at the back end of every posit FPU operation unit, mirroring the field extraction done at the operand-classification front end. Valid/ready handshake on both sides with full backpressure.

---
 rtl/posit_pkg.sv | 23 ++
 rtl/posit_packer.sv | 99 +++++++++
 tb/tb_posit_packer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: posit format enumeration and derived field-width helpers
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT16_ES1 = 2'd0,
        POSIT8_ES2  = 2'd1,
        POSIT32_ES2 = 2'd2
    } posit_format_e;

    function automatic int posit_width(posit_format_e f);
        return (f == POSIT8_ES2) ? 8 : (f == POSIT32_ES2) ? 32 : 16;
    endfunction

    function automatic int exp_bits(posit_format_e f);
        return (f == POSIT16_ES1) ? 1 : 2;
    endfunction

    // one extra bit so out-of-range regimes reach the packer and saturate
    function automatic int max_regime_bits(posit_format_e f);
        return $clog2(posit_width(f)) + 1;
    endfunction

endpackage

// File: rtl/posit_packer.sv
// posit_packer: two-stage pipelined posit encoder with RNE rounding and valid/ready handshake
module posit_packer #(
    parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
    localparam int WIDTH           = posit_pkg::posit_width(pFormat),
    localparam int EXP_BITS        = posit_pkg::exp_bits(pFormat),
    localparam int MAX_REGIME_BITS = posit_pkg::max_regime_bits(pFormat)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       sign_i,
    input  logic signed [MAX_REGIME_BITS:0] regime_i,
    input  logic [EXP_BITS-1:0]        exponent_i,
    input  logic [WIDTH-1:0]           fraction_i,
    input  logic                       sticky_i,
    input  logic                       is_zero_i,
    input  logic                       is_NaR_i,
    output logic [WIDTH-1:0]           result_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o
);

    localparam int RW = MAX_REGIME_BITS + 1;
    localparam int FW = 2 * WIDTH + EXP_BITS;
    localparam int VW = FW + WIDTH;
    localparam logic signed [RW-1:0] K_MAX = RW'(WIDTH - 2);
    localparam logic signed [RW-1:0] K_MIN = RW'(-(WIDTH - 1));

    logic              v1, v2, s1_adv, s2_adv;
    logic              sat_hi, sat_lo, pol;
    logic signed [RW-1:0] kc;
    logic [RW-1:0]     rl, sh;
    logic [VW-1:0]     vec;
    logic [FW-1:0]     field_d;
    logic              s1_sign, s1_sticky, s1_zero, s1_nar, s1_hi, s1_lo;
    logic [FW-1:0]     s1_field;
    logic [WIDTH-2:0]  mag, fin;
    logic [WIDTH-1:0]  mag_r, res;
    logic              guard, st;
    logic              unused_hidden;

    assign unused_hidden = fraction_i[WIDTH-1];
    assign s2_adv      = ~v2 | out_ready_i;
    assign s1_adv      = ~v1 | s2_adv;
    assign in_ready_o  = s1_adv;
    assign out_valid_o = v2;
    assign busy_o      = v1 | v2;

    // assemble: clamp k, build the regime run and left-align regime|exponent|fraction
    always_comb begin
        sat_hi  = regime_i > K_MAX;
        sat_lo  = regime_i < K_MIN;
        kc      = sat_hi ? K_MAX : sat_lo ? K_MIN : regime_i;
        rl      = kc[RW-1] ? -kc : kc + RW'(1);
        sh      = RW'(WIDTH) - rl;
        pol     = ~kc[RW-1];
        vec     = {{WIDTH{pol}}, ~pol, exponent_i, fraction_i[WIDTH-2:0], {WIDTH{1'b0}}};
        field_d = FW'(vec << sh >> WIDTH);
    end

    // round to nearest even, saturate to maxpos/minpos, negate, apply specials
    always_comb begin
        mag   = s1_field[FW-1 -: WIDTH-1];
        guard = s1_field[FW-WIDTH];
        st    = |s1_field[FW-WIDTH-1:0] | s1_sticky;
        mag_r = {1'b0, mag} + WIDTH'(guard & (mag[0] | st));
        fin   = (s1_hi | mag_r[WIDTH-1]) ? '1 : (s1_lo | ~|mag_r) ? (WIDTH-1)'(1) : mag_r[WIDTH-2:0];
        res   = s1_nar ? {1'b1, {(WIDTH-1){1'b0}}} : s1_zero ? '0 : s1_sign ? -{1'b0, fin} : {1'b0, fin};
    end

    // stage-1 data: loads whenever stage 1 advances, no reset needed
    always_ff @(posedge clk_i) begin
        if (s1_adv) begin
            s1_field  <= field_d;
            s1_sign   <= sign_i;
            s1_sticky <= sticky_i;
            s1_zero   <= is_zero_i;
            s1_nar    <= is_NaR_i;
            s1_hi     <= sat_hi;
            s1_lo     <= sat_lo;
        end
    end

    // valid bits and output word; in-flight beats vanish on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            result_o <= '0;
        end else begin
            if (s1_adv) v1 <= in_valid_i;
            if (s2_adv) v2 <= v1;
            if (s2_adv && v1) result_o <= res;
        end
    end

endmodule

// File: tb/tb_posit_packer.sv
// tb_posit_packer: vector table plus scoreboard checks for the posit packer pipeline
module tb_posit_packer;

    typedef struct {
        logic        s;
        int          k;
        logic        e;
        logic [15:0] f;
        logic        st;
        logic        z;
        logic        n;
        logic [15:0] r;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        sign_i = 1'b0;
    logic [5:0]  regime_i = '0;
    logic [0:0]  exponent_i = '0;
    logic [15:0] fraction_i = '0;
    logic        sticky_i = 1'b0;
    logic        is_zero_i = 1'b0;
    logic        is_NaR_i = 1'b0;
    logic [15:0] result_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    vec_t tbl[$];
    vec_t idle, va, vb, vc;
    logic acc;

    always #5 clk_i = ~clk_i;

    posit_packer dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sign_i(sign_i), .regime_i(regime_i), .exponent_i(exponent_i), .fraction_i(fraction_i),
        .sticky_i(sticky_i), .is_zero_i(is_zero_i), .is_NaR_i(is_NaR_i), .result_o(result_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic s, input int k, input logic e, input logic [15:0] f,
                                input logic st, input logic z, input logic n, input logic [15:0] r);
        vec_t v;
        v.s = s; v.k = k; v.e = e; v.f = f; v.st = st; v.z = z; v.n = n; v.r = r;
        return v;
    endfunction

    // one cycle: drive at negedge, settle, log transfers, cross the rising edge
    task automatic step(input logic iv, input logic ordy, input vec_t v, output logic accepted);
        in_valid_i = iv; out_ready_i = ordy;
        sign_i = v.s; regime_i = 6'(v.k); exponent_i = v.e; fraction_i = v.f;
        sticky_i = v.st; is_zero_i = v.z; is_NaR_i = v.n;
        #1;
        accepted = iv && in_ready_o;
        if (accepted) exp_q.push_back(v.r);
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_extra: got %h, required no output", result_o);
            end else check("sb_result", result_o, exp_q.pop_front());
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 1'b1, idle, acc);
        check("sb_drained", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        idle = mk(0, 0, 0, 16'h8000, 0, 0, 0, 16'h0000);
        tbl.push_back(mk(0,   0, 0, 16'h8000, 0, 0, 0, 16'h4000));
        tbl.push_back(mk(1,   0, 0, 16'h8000, 0, 0, 0, 16'hC000));
        tbl.push_back(mk(0,   0, 0, 16'h8004, 0, 0, 0, 16'h4000));
        tbl.push_back(mk(0,   0, 0, 16'h8004, 1, 0, 0, 16'h4001));
        tbl.push_back(mk(0,  20, 0, 16'h8000, 0, 0, 0, 16'h7FFF));
        tbl.push_back(mk(1, -20, 0, 16'h8000, 0, 0, 0, 16'hFFFF));
        tbl.push_back(mk(0,  14, 1, 16'hFFFF, 0, 0, 0, 16'h7FFF));
        tbl.push_back(mk(0,  15, 0, 16'h8000, 0, 0, 0, 16'h7FFF));
        tbl.push_back(mk(0,  13, 1, 16'h8000, 0, 0, 0, 16'h7FFE));
        tbl.push_back(mk(0,  13, 1, 16'h8000, 1, 0, 0, 16'h7FFF));
        tbl.push_back(mk(0, -15, 0, 16'h8000, 0, 0, 0, 16'h0001));
        tbl.push_back(mk(0, -15, 0, 16'h8000, 1, 0, 0, 16'h0001));
        tbl.push_back(mk(0, -16, 1, 16'hFFFF, 1, 0, 0, 16'h0001));
        tbl.push_back(mk(0,   1, 1, 16'h8000, 0, 0, 0, 16'h6800));
        tbl.push_back(mk(0,  -1, 0, 16'hC000, 0, 0, 0, 16'h2800));
        tbl.push_back(mk(1,  -2, 1, 16'h8000, 0, 0, 0, 16'hE800));
        tbl.push_back(mk(0,   0, 1, 16'hFFFF, 0, 0, 0, 16'h6000));
        tbl.push_back(mk(0,   3, 1, 16'hABCD, 0, 1, 1, 16'h8000));
        tbl.push_back(mk(1,   3, 1, 16'hABCD, 0, 0, 1, 16'h8000));
        tbl.push_back(mk(1,   3, 1, 16'hABCD, 0, 1, 0, 16'h0000));

        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_out_valid", 16'(out_valid_o), 16'd0);
        check("rst_busy", 16'(busy_o), 16'd0);
        check("rst_result", result_o, 16'h0000);
        rst_i = 1'b0;
        #1;
        check("rst_in_ready", 16'(in_ready_o), 16'd1);
        @(negedge clk_i);

        step(1'b1, 1'b1, tbl[0], acc);
        check("lat_edge1", 16'(out_valid_o), 16'd0);
        step(1'b0, 1'b1, idle, acc);
        check("lat_edge2", 16'(out_valid_o), 16'd1);
        drain();

        foreach (tbl[i]) step(1'b1, 1'b1, tbl[i], acc);
        drain();

        va = tbl[13]; vb = tbl[15]; vc = tbl[3];
        step(1'b1, 1'b0, va, acc);
        check("bp_acc1", 16'(acc), 16'd1);
        step(1'b1, 1'b0, vb, acc);
        check("bp_acc2", 16'(acc), 16'd1);
        check("bp_in_ready", 16'(in_ready_o), 16'd0);
        check("bp_result", result_o, va.r);
        step(1'b1, 1'b0, vc, acc);
        check("bp_acc3", 16'(acc), 16'd0);
        check("bp_hold_valid", 16'(out_valid_o), 16'd1);
        check("bp_hold_result", result_o, va.r);
        step(1'b1, 1'b1, vc, acc);
        check("bp_passthru", 16'(acc), 16'd1);
        check("bp_out1", 16'(out_valid_o), 16'd1);
        step(1'b0, 1'b1, idle, acc);
        check("bp_out2", 16'(out_valid_o), 16'd1);
        step(1'b0, 1'b1, idle, acc);
        drain();

        step(1'b1, 1'b0, va, acc);
        step(1'b1, 1'b0, vb, acc);
        check("pre_rst_busy", 16'(busy_o), 16'd1);
        rst_i = 1'b1;
        #1;
        check("arst_out_valid", 16'(out_valid_o), 16'd0);
        check("arst_busy", 16'(busy_o), 16'd0);
        check("arst_result", result_o, 16'h0000);
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, idle, acc);
            check("post_rst_quiet", 16'(out_valid_o), 16'd0);
        end
        step(1'b1, 1'b1, tbl[1], acc);
        check("post_rst_edge1", 16'(out_valid_o), 16'd0);
        step(1'b0, 1'b1, idle, acc);
        check("post_rst_edge2", 16'(out_valid_o), 16'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
